// File: rtl/shift_arb_pkg.sv
// Purpose : shared types and helpers for the shift_arbiter slice.
// Latency : n/a (package only).
// Backpressure : n/a.
// Contents: DW/AW widths, FSM state encoding, rr_pick round-robin grant function.
package shift_arb_pkg;

  localparam int DW      = 24;
  localparam int AW      = 5;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  // One-hot grant of the first set bit at or above ptr, wrapping at nreq.
  // ptr is always < nreq, so ptr+k (k < nreq) wraps with one subtraction.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [1:0]         ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] gnt;
    int                 tmp;
    logic [1:0]         idx;
    gnt = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      tmp = int'(ptr) + k;
      if (tmp >= nreq) tmp = tmp - nreq;
      idx = tmp[1:0];
      if ((k < nreq) && (gnt == '0) && valid[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Purpose : combinational DW-bit logical left shifter; amounts >= DW give zero.
// Latency : 0 cycles (pure combinational).
// Backpressure : none, no handshake.
// Ports: tbsh = operand, s = shift amount (8-bit, zero-extended by caller), sh = result.
module shift_unit #(
  parameter int DW = 24
) (
  input  logic [DW-1:0] tbsh,
  input  logic [7:0]    s,
  output logic [DW-1:0] sh
);

  always_comb begin
    if (int'(s) >= DW) sh = '0;
    else               sh = tbsh << s;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Purpose : round-robin share of one shift_unit between NREQ requesters, one op in flight.
// Latency : accept at cycle T -> rsp_valid at T+2; best throughput one result per 3 cycles.
// Backpressure : result held stable in RESP until rsp_ready; req_ready only asserted in IDLE.
// Ports: clk/rst (sync, active-high); req_valid/req_data/req_amt/req_ready per requester
//        (slices i*DW, i*AW); rsp_valid/rsp_ready/rsp_data/rsp_id result side;
//        rsp_ovf (only when SHIFT_ARB_OVF_EN is defined) flags 1 bits shifted out.
module shift_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = shift_arb_pkg::DW,
  parameter int AW   = shift_arb_pkg::AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*AW-1:0] req_amt,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic [1:0]         rsp_id
`ifdef SHIFT_ARB_OVF_EN
  ,
  output logic               rsp_ovf
`endif
);

  import shift_arb_pkg::*;

  state_e             state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]      op_a_q, op_a_d;
  logic [AW-1:0]      op_s_q, op_s_d;
  logic [1:0]         op_id_q, op_id_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;
  logic [1:0]         rsp_id_q, rsp_id_d;

  logic [MAX_REQ-1:0] valid_w;
  logic [MAX_REQ-1:0] grant_w;
  logic [1:0]         grant_id;
  logic [DW-1:0]      grant_a;
  logic [AW-1:0]      grant_s;
  logic [7:0]         sh_amt;
  logic [DW-1:0]      sh;

  // Arbitration -------------------------------------------------------------
  always_comb begin
    valid_w              = '0;
    valid_w[NREQ-1:0]    = req_valid;
  end

  assign grant_w = rr_pick(valid_w, rr_ptr_q, NREQ);

  always_comb begin
    grant_id = 2'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (grant_w[i]) grant_id = 2'(i);
    end
  end

  always_comb begin
    grant_a = '0;
    grant_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_w[i]) begin
        grant_a = req_data[i*DW +: DW];
        grant_s = req_amt[i*AW +: AW];
      end
    end
  end

  // Gated by rst so a held request never sees ready while reset is asserted.
  assign req_ready = ((state_q == IDLE) && !rst) ? grant_w[NREQ-1:0] : '0;

  // Datapath ----------------------------------------------------------------
  assign sh_amt = 8'(op_s_q);

  shift_unit #(.DW(DW)) u_shift_unit (
    .tbsh (op_a_q),
    .s    (sh_amt),
    .sh   (sh)
  );

`ifdef SHIFT_ARB_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;
  logic ovf_w;

  // Bits pushed past the top: the top op_s bits of op_a, or all of it when op_s >= DW.
  // op_s == 0 shifts right by DW, which yields zero.
  always_comb begin
    if (int'(op_s_q) >= DW) ovf_w = |op_a_q;
    else                    ovf_w = |(op_a_q >> (DW - int'(op_s_q)));
  end
`endif

  // FSM ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_s_d     = op_s_q;
    op_id_d    = op_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifdef SHIFT_ARB_OVF_EN
    rsp_ovf_d  = rsp_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          op_a_d  = grant_a;
          op_s_d  = grant_s;
          op_id_d = grant_id;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rsp_data_d = sh;
        rsp_id_d   = op_id_q;
`ifdef SHIFT_ARB_OVF_EN
        rsp_ovf_d  = ovf_w;
`endif
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          // Pointer moves past the requester just served, only on retire.
          rr_ptr_d = (int'(op_id_q) == NREQ - 1) ? 2'd0 : op_id_q + 2'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      op_a_q     <= '0;
      op_s_q     <= '0;
      op_id_q    <= 2'd0;
      rsp_data_q <= '0;
      rsp_id_q   <= 2'd0;
`ifdef SHIFT_ARB_OVF_EN
      rsp_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_s_q     <= op_s_d;
      op_id_q    <= op_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
`ifdef SHIFT_ARB_OVF_EN
      rsp_ovf_q  <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
`ifdef SHIFT_ARB_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose : directed self-checking bench for shift_arbiter (NREQ=2, DW=24, AW=5).
// Latency : checks accept at T -> rsp_valid at T+2 and 3-cycle throughput.
// Backpressure : holds rsp_ready low in RESP and checks the result stays put.
module tb_shift_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 24;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*AW-1:0] req_amt;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [1:0]         rsp_id;
`ifdef SHIFT_ARB_OVF_EN
  logic               rsp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  shift_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req_data[0 +: DW]  = 24'h000003;
    req_amt[0 +: AW]   = 5'd2;
    req_data[DW +: DW] = 24'h000100;
    req_amt[AW +: AW]  = 5'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++;
      if (rsp_data !== 24'h0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 000000", rsp_data); end
      checks++;
      if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'h00000C) begin
      failures++;
      $display("FAIL reset_first_rsp: got v=%b id=%0d d=%h expected v=1 id=0 d=00000c", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req_data[0 +: DW] = 24'h000001;
    req_amt[0 +: AW]  = 5'd5;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready_T: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_valid_T1: got %b expected 0", rsp_valid); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid_T2: got %b expected 1", rsp_valid); end
    checks++;
    if (rsp_data !== 24'h000020) begin failures++; $display("FAIL single_data: got %h expected 000020", rsp_data); end
    checks++;
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id: got %0d expected 0", rsp_id); end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_retire: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0]      exp_id  [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [DW-1:0]   exp_dat [4] = '{24'h000020, 24'h000030, 24'h000020, 24'h000030};
    int n;
    apply_reset();
    req_data[0 +: DW]  = 24'h000010;
    req_amt[0 +: AW]   = 5'd1;
    req_data[DW +: DW] = 24'h000003;
    req_amt[AW +: AW]  = 5'd4;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 8) begin tick(); n++; end
      checks++;
      if (req_ready !== exp_gnt[k]) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_gnt[k]); end
      if (k > 0) begin
        checks++;
        if (n != 0) begin failures++; $display("FAIL rr_throughput%0d: waited %0d cycles expected 0", k, n); end
      end
      tick();
      checks++;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_ready_shift%0d: got %b expected 00", k, req_ready); end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id[k] || rsp_data !== exp_dat[k]) begin
        failures++;
        $display("FAIL rr_rsp%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, exp_id[k], exp_dat[k]);
      end
      checks++;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_no_bypass%0d: got %b expected 00", k, req_ready); end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_data[0 +: DW] = 24'h000123;
    req_amt[0 +: AW]  = 5'd4;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready_shift: got %b expected 00", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 24'h001230 || rsp_id !== 2'd0 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b expected v=1 d=001230 id=0 rdy=00", i, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_at_ready: got %b expected 1", rsp_valid); end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_retire: got %b expected 0", rsp_valid); end
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_boundary();
    logic [DW-1:0] dat [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h800001, 24'h0FFFFF};
    logic [AW-1:0] amt [6] = '{5'd23, 5'd24, 5'd31, 5'd0, 5'd1, 5'd4};
    logic [DW-1:0] exp [6] = '{24'h800000, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h000002, 24'hFFFFF0};
`ifdef SHIFT_ARB_OVF_EN
    logic          eovf [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    int n;
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_data[0 +: DW] = dat[k];
      req_amt[0 +: AW]  = amt[k];
      req_valid = 2'b01;
      #1;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 8) begin tick(); n++; end
      tick();
      req_valid = 2'b00;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 8) begin tick(); n++; end
      checks++;
      if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bnd_timeout%0d: rsp_valid=%b expected 1", k, rsp_valid); end
      checks++;
      if (rsp_data !== exp[k]) begin failures++; $display("FAIL bnd_data%0d: got %h expected %h", k, rsp_data, exp[k]); end
`ifdef SHIFT_ARB_OVF_EN
      checks++;
      if (rsp_ovf !== eovf[k]) begin failures++; $display("FAIL bnd_ovf%0d: got %b expected %b", k, rsp_ovf, eovf[k]); end
`endif
      tick();
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    req_data[DW +: DW] = 24'h000005;
    req_amt[AW +: AW]  = 5'd2;
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL midop_grant: got %b expected 10", req_ready); end
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 24'h0) begin
        failures++;
        $display("FAIL midop_no_rsp%0d: got v=%b d=%h expected v=0 d=000000", i, rsp_valid, rsp_data);
      end
      tick();
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL midop_ptr_reset: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
